alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter for one shared combinational ALU
// Define ALU_ARBITER_FIXED_PRIORITY_EN to make requester 0 always win ties.
module alu_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_control,
  input  logic [31:0] req0_input1,
  input  logic [31:0] req0_input2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_control,
  input  logic [31:0] req1_input1,
  input  logic [31:0] req1_input2,
  output logic [3:0]  ALUControl,
  output logic [31:0] input1,
  output logic [31:0] input2,
  input  logic [31:0] ALUOut,
  input  logic        zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_illegal
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t state;
  logic   id_q;
  logic   window;
  logic   prefer0;
  logic   grant0;
  logic   grant1;
  logic   accept;

  function automatic logic is_illegal(input logic [3:0] code);
    case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: is_illegal = 1'b0;
      default:                                                is_illegal = 1'b1;
    endcase
  endfunction

`ifdef ALU_ARBITER_FIXED_PRIORITY_EN
  assign prefer0 = 1'b1;
`else
  // last_grant=1 means requester 1 won last time, so requester 0 wins the next tie
  logic last_grant;
  assign prefer0 = last_grant;
`endif

  assign window     = (state == IDLE) || ((state == HOLD) && rsp_ready);
  assign grant0     = req0_valid & (~req1_valid | prefer0);
  assign grant1     = req1_valid & (~req0_valid | ~prefer0);
  assign req0_ready = window & grant0;
  assign req1_ready = window & grant1;
  assign accept     = window & (req0_valid | req1_valid);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      id_q        <= 1'b0;
      ALUControl  <= 4'd0;
      input1      <= 32'd0;
      input2      <= 32'd0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= 32'd0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
`ifndef ALU_ARBITER_FIXED_PRIORITY_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      case (state)
        ISSUE: begin
          rsp_valid   <= 1'b1;
          rsp_id      <= id_q;
          rsp_result  <= ALUOut;
          rsp_zero    <= zero;
          rsp_illegal <= is_illegal(ALUControl);
          ALUControl  <= 4'd0;
          input1      <= 32'd0;
          input2      <= 32'd0;
          state       <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // acceptance only happens in IDLE or on the HOLD handshake, so it overrides the case above
      if (accept) begin
        state      <= ISSUE;
        id_q       <= grant1;
        ALUControl <= grant1 ? req1_control : req0_control;
        input1     <= grant1 ? req1_input1  : req0_input1;
        input2     <= grant1 ? req1_input2  : req0_input2;
`ifndef ALU_ARBITER_FIXED_PRIORITY_EN
        last_grant <= grant1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU and scoreboard
module tb_alu_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_control, req1_control, ALUControl;
  logic [31:0] req0_input1, req0_input2, req1_input1, req1_input2;
  logic [31:0] input1, input2, ALUOut, rsp_result;
  logic        zero, rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_illegal;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          at_edge;
  } exp_t;
  exp_t sb[$];

  alu_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_control(req0_control),
    .req0_input1(req0_input1), .req0_input2(req0_input2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_control(req1_control),
    .req1_input1(req1_input1), .req1_input2(req1_input2),
    .ALUControl(ALUControl), .input1(input1), .input2(input2),
    .ALUOut(ALUOut), .zero(zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic legal_code(input logic [3:0] c);
    return c inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
  endfunction

  always_comb begin
    ALUOut = alu_fn(ALUControl, input1, input2);
    zero   = (ALUOut == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic set_req0(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_control = c; req0_input1 = a; req0_input2 = b;
  endtask

  task automatic set_req1(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_control = c; req1_input1 = a; req1_input2 = b;
  endtask

  function automatic logic [3:0] rand_code();
    logic [3:0] legal [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    if ($urandom_range(0, 4) == 0) return 4'($urandom_range(0, 15));
    return legal[$urandom_range(0, 5)];
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic model_last;
    logic pred;
    logic acc0, acc1;
    int   accepted, got, last_acc, guard;
    exp_t e;

    reset = 1'b0;
    rsp_ready = 1'b1;
    set_req0(0, 0, 0, 0);
    set_req1(0, 0, 0, 0);
    repeat (2) tick();

    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_result", rsp_result, 0);
    check("reset_rsp_zero", rsp_zero, 0);
    check("reset_rsp_illegal", rsp_illegal, 0);
    check("reset_alu_control", ALUControl, 0);
    check("reset_input1", input1, 0);
    check("reset_input2", input2, 0);
    check("reset_ready0", req0_ready, 0);
    check("reset_ready1", req1_ready, 0);

    // single op, accepted on the first edge after release
    set_req0(1, 4'b0010, 5, 7);
    reset = 1'b1;
    #1;
    check("single_ready0", req0_ready, 1);
    check("single_ready1", req1_ready, 0);
    tick();
    set_req0(0, 0, 0, 0);
    check("single_issue_ctl", ALUControl, 4'b0010);
    check("single_issue_in1", input1, 5);
    check("single_issue_in2", input2, 7);
    check("single_issue_valid", rsp_valid, 0);
    tick();
    check("single_valid", rsp_valid, 1);
    check("single_result", rsp_result, 12);
    check("single_zero", rsp_zero, 0);
    check("single_id", rsp_id, 0);
    check("single_illegal", rsp_illegal, 0);
    check("single_hold_ctl", ALUControl, 0);
    tick();
    check("single_done", rsp_valid, 0);

    // tie straight after reset
    reset = 1'b0; #1; reset = 1'b1;
    set_req0(1, 4'b0110, 9, 9);
    set_req1(1, 4'b0000, 32'hF0, 32'h0F);
    #1;
    check("tie_ready0", req0_ready, 1);
    check("tie_ready1", req1_ready, 0);
    tick();
    check("tie_issue_ready0", req0_ready, 0);
    check("tie_issue_ready1", req1_ready, 0);
    tick();
    check("tie_first_valid", rsp_valid, 1);
    check("tie_first_result", rsp_result, 0);
    check("tie_first_zero", rsp_zero, 1);
    check("tie_first_id", rsp_id, 0);
`ifdef ALU_ARBITER_FIXED_PRIORITY_EN
    check("tie_second_ready0", req0_ready, 1);
    check("tie_second_ready1", req1_ready, 0);
`else
    check("tie_second_ready0", req0_ready, 0);
    check("tie_second_ready1", req1_ready, 1);
`endif
    tick();
    set_req1(0, 0, 0, 0);
`ifdef ALU_ARBITER_FIXED_PRIORITY_EN
    check("tie_second_in1", input1, 9);
`else
    check("tie_second_in1", input1, 32'hF0);
`endif
    set_req0(0, 0, 0, 0);
    tick();
    check("tie_second_valid", rsp_valid, 1);
    check("tie_second_result", rsp_result, 0);
    check("tie_second_zero", rsp_zero, 1);
`ifdef ALU_ARBITER_FIXED_PRIORITY_EN
    check("tie_second_id", rsp_id, 0);
`else
    check("tie_second_id", rsp_id, 1);
`endif
    tick();
    check("tie_done", rsp_valid, 0);

    // backpressure
    rsp_ready = 1'b0;
    set_req0(1, 4'b0010, 100, 23);
    tick();
    set_req0(0, 0, 0, 0);
    tick();
    check("bp_valid", rsp_valid, 1);
    set_req1(1, 4'b0110, 50, 8);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_result", rsp_result, 123);
      check("bp_hold_id", rsp_id, 0);
      check("bp_hold_ready0", req0_ready, 0);
      check("bp_hold_ready1", req1_ready, 0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready1", req1_ready, 1);
    tick();
    set_req1(0, 0, 0, 0);
    check("bp_next_issue_ctl", ALUControl, 4'b0110);
    check("bp_next_issue_in1", input1, 50);
    check("bp_next_issue_valid", rsp_valid, 0);
    tick();
    check("bp_next_valid", rsp_valid, 1);
    check("bp_next_result", rsp_result, 42);
    check("bp_next_id", rsp_id, 1);
    tick();

    // illegal code still issued
    set_req0(1, 4'b1111, 3, 4);
    tick();
    set_req0(0, 0, 0, 0);
    check("illegal_issue_ctl", ALUControl, 4'b1111);
    tick();
    check("illegal_valid", rsp_valid, 1);
    check("illegal_result", rsp_result, 0);
    check("illegal_flag", rsp_illegal, 1);
    tick();

    // reset during ISSUE
    set_req1(1, 4'b0010, 1, 1);
    tick();
    set_req1(0, 0, 0, 0);
    check("rst_issue_pre_ctl", ALUControl, 4'b0010);
    #2 reset = 1'b0;
    #1;
    check("rst_issue_valid", rsp_valid, 0);
    check("rst_issue_ctl", ALUControl, 0);
    check("rst_issue_in1", input1, 0);
    check("rst_issue_in2", input2, 0);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_issue_after_valid", rsp_valid, 0);
    end

    // reset during HOLD
    set_req0(1, 4'b0010, 2, 2);
    tick();
    set_req0(0, 0, 0, 0);
    tick();
    check("rst_hold_pre_valid", rsp_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_hold_valid", rsp_valid, 0);
    check("rst_hold_result", rsp_result, 0);
    check("rst_hold_ctl", ALUControl, 0);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold_after_valid", rsp_valid, 0);
    end

    // 100 random back-to-back requests; requester 0 always valid, requester 1 toggles freely
    reset = 1'b0; #1; reset = 1'b1;
    model_last = 1'b1;
    accepted = 0; got = 0; last_acc = -1; guard = 0;
    rsp_ready = 1'b1;
    set_req0(1, rand_code(), rand_operand(), rand_operand());
    set_req1($urandom_range(0, 1) == 1, rand_code(), rand_operand(), rand_operand());
    while (got < 100 && guard < 1000) begin
      #1;
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      if (acc0 || acc1) begin
`ifdef ALU_ARBITER_FIXED_PRIORITY_EN
        pred = req1_valid & ~req0_valid;
`else
        pred = (req0_valid && req1_valid) ? ~model_last : req1_valid;
`endif
        check("rnd_grant", acc1, pred);
        check("rnd_one_grant", acc0 & acc1, 0);
        model_last = pred;
        e.id      = pred;
        e.res     = pred ? alu_fn(req1_control, req1_input1, req1_input2)
                         : alu_fn(req0_control, req0_input1, req0_input2);
        e.z       = (e.res == 32'd0);
        e.ill     = pred ? ~legal_code(req1_control) : ~legal_code(req0_control);
        e.at_edge = cyc + 1;
        if (last_acc >= 0) check("rnd_throughput", e.at_edge - last_acc, 2);
        last_acc = e.at_edge;
        sb.push_back(e);
        accepted++;
      end
      tick();
      guard++;
      if (acc0) set_req0(accepted < 100, rand_code(), rand_operand(), rand_operand());
      if (acc1) set_req1(1, rand_code(), rand_operand(), rand_operand());
      req1_valid = (accepted < 100) && ($urandom_range(0, 1) == 1);
      if (accepted >= 100) req0_valid = 1'b0;
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rnd_spurious_rsp", rsp_valid, 0);
        end else begin
          e = sb.pop_front();
          check("rnd_id", rsp_id, e.id);
          check("rnd_result", rsp_result, e.res);
          check("rnd_zero", rsp_zero, e.z);
          check("rnd_illegal", rsp_illegal, e.ill);
          check("rnd_latency", cyc, e.at_edge + 1);
          got++;
        end
      end
    end
    check("rnd_count", got, 100);
    check("rnd_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
